// File: rtl/spi_slave.sv
// SPI target that runs entirely in the sys_clk domain.
// sclk, cs_n and mosi pass through synchronizers. Edges of sclk are found by
// comparing the synchronized level with its delayed copy. Frames are 8-32 bits
// long and may follow each other back to back under one cs_n assertion.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [15:0] control,
    input  logic        tx_data_valid,
    output logic        tx_data_ready,
    input  logic [31:0] tx_data,
    output logic [31:0] rx_data,
    output logic        rx_data_valid,
    output logic        tx_underrun,
    output logic        frame_abort
);

    // IDLE: cs_n_s high. LOADED: frame started, no bit sampled yet.
    // SHIFTING: some bits sampled, frame incomplete.
    // DONE: final bit sampled; the next sclk edge starts a new frame.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADED,
        ST_SHIFTING,
        ST_DONE
    } frame_state_t;

    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] cs_n_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sclk_s;
    logic                   cs_n_s;
    logic                   mosi_s;
    logic                   sclk_d;
    logic                   cs_n_d;

    logic [4:0]             ctl_len;
    logic [4:0]             cfg_len;
    logic                   cfg_cpha;
    logic                   cfg_cpol;

    frame_state_t           state;
    logic [4:0]             bit_cnt;
    logic [31:0]            tx_word;
    logic [31:0]            tx_buf;
    logic [31:0]            rx_shift;

    logic                   sclk_edge;
    logic                   lead_edge;
    logic                   trail_edge;
    logic                   sample_edge;
    logic                   drive_edge;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   start_on_edge;
    logic                   frame_start;
    logic                   accept;
    logic                   tx_full;
    logic [31:0]            start_word;
    logic [31:0]            rx_next;
    logic                   unused_ctl;

    // A bit_length field of zero is shorthand for an 8-bit frame.
    assign ctl_len    = (control[15:11] == 5'd0) ? 5'd7 : control[15:11];
    assign unused_ctl = ^{control[10:5], control[2:0]};

    assign sclk_s = sclk_pipe[SYNC_STAGES-1];
    assign cs_n_s = cs_n_pipe[SYNC_STAGES-1];
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    assign sclk_edge     = (sclk_s != sclk_d) && !cs_n_s;
    assign lead_edge     = sclk_edge && (sclk_d == cfg_cpol);
    assign trail_edge    = sclk_edge && (sclk_d != cfg_cpol);
    assign sample_edge   = cfg_cpha ? trail_edge : lead_edge;
    assign drive_edge    = cfg_cpha ? lead_edge : trail_edge;
    assign cs_fall       = cs_n_d && !cs_n_s;
    assign cs_rise       = !cs_n_d && cs_n_s;
    assign start_on_edge = sclk_edge && (state == ST_DONE);
    assign frame_start   = cs_fall || start_on_edge;

    assign tx_full    = ~tx_data_ready;
    assign accept     = tx_data_valid && tx_data_ready;
    assign start_word = tx_full ? tx_buf : 32'd0;
    assign rx_next    = {rx_shift[30:0], mosi_s};

    // Synchronize the pins and keep one-cycle-delayed copies for edge detection.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sclk_pipe <= {SYNC_STAGES{control[3]}};
            cs_n_pipe <= '1;
            mosi_pipe <= '0;
            sclk_d    <= control[3];
            cs_n_d    <= 1'b1;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
            cs_n_pipe <= {cs_n_pipe[SYNC_STAGES-2:0], cs_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_n_d    <= cs_n_s;
        end
    end

    // Track control only while deselected, so the mode is frozen for a whole burst.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || cs_n_s) begin
            cfg_len  <= ctl_len;
            cfg_cpha <= control[4];
            cfg_cpol <= control[3];
        end
    end

    // Frame engine: tx buffer handshake, bit counting, shifting and status pulses.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= 5'd0;
            tx_word       <= 32'd0;
            tx_buf        <= 32'd0;
            tx_data_ready <= 1'b1;
            rx_shift      <= 32'd0;
            rx_data       <= 32'd0;
            rx_data_valid <= 1'b0;
            tx_underrun   <= 1'b0;
            frame_abort   <= 1'b0;
            miso          <= 1'b0;
            miso_oe       <= 1'b0;
        end else begin
            rx_data_valid <= 1'b0;
            tx_underrun   <= 1'b0;
            frame_abort   <= 1'b0;
            miso_oe       <= ~cs_n_s;

            // An accept can only coincide with a transfer when the buffer was
            // empty, so the accepted word is kept for the following frame.
            if (accept) begin
                tx_buf        <= tx_data;
                tx_data_ready <= 1'b0;
            end else if (frame_start) begin
                tx_data_ready <= 1'b1;
            end

            if (cs_n_s) begin
                miso     <= 1'b0;
                state    <= ST_IDLE;
                rx_shift <= 32'd0;
                bit_cnt  <= cfg_len;
                if (cs_rise && (state == ST_SHIFTING)) begin
                    frame_abort <= 1'b1;
                end
            end else if (frame_start) begin
                state       <= ST_LOADED;
                bit_cnt     <= cfg_len;
                rx_shift    <= 32'd0;
                tx_word     <= start_word;
                tx_underrun <= tx_data_ready;
                // The edge that opens a back-to-back frame is always a drive edge;
                // with CPHA=1 the first frame's MSB waits for its leading edge.
                if (start_on_edge || !cfg_cpha) begin
                    miso <= start_word[cfg_len];
                end
            end else begin
                if (sample_edge) begin
                    rx_shift <= rx_next;
                    if (bit_cnt == 5'd0) begin
                        rx_data       <= rx_next;
                        rx_data_valid <= 1'b1;
                        bit_cnt       <= cfg_len;
                        state         <= ST_DONE;
                    end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                        state   <= ST_SHIFTING;
                    end
                end
                if (drive_edge) begin
                    miso <= tx_word[bit_cnt];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master, a host feeding
// the tx buffer from a queue, and an rx scoreboard checked on rx_data_valid.
module tb_spi_slave;

    localparam int HALF = 8;

    typedef struct {
        logic [15:0] ctl;
        int          nbits;
        logic [31:0] tx;
        logic [31:0] mosi;
        logic [31:0] exp_rx;
        logic [31:0] exp_miso;
    } vec_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [15:0] control;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic [31:0] tx_data;
    logic [31:0] rx_data;
    logic        rx_data_valid;
    logic        tx_underrun;
    logic        frame_abort;

    int          checks = 0;
    int          passes = 0;
    int          rx_cnt = 0;
    int          ur_cnt = 0;
    int          ab_cnt = 0;
    logic [31:0] last_rx;
    logic [31:0] sb_q[$];
    logic [31:0] host_q[$];

    spi_slave #(.SYNC_STAGES(2)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .sclk          (sclk),
        .cs_n          (cs_n),
        .mosi          (mosi),
        .miso          (miso),
        .miso_oe       (miso_oe),
        .control       (control),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx_data       (tx_data),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .tx_underrun   (tx_underrun),
        .frame_abort   (frame_abort)
    );

    // 100 MHz system clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Stop a hung run with a visible failure.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic logic [15:0] mk_ctl(input logic [4:0] len, input logic cpol, input logic cpha);
        return {len, 6'd0, cpha, cpol, 3'd0};
    endfunction

    // Host side of the tx buffer: offer queued words, drop valid once accepted.
    initial begin : host
        logic prev_ready;
        prev_ready    = 1'b0;
        tx_data_valid = 1'b0;
        tx_data       = 32'd0;
        forever begin
            @(negedge sys_clk);
            if (tx_data_valid && prev_ready) begin
                tx_data_valid = 1'b0;
            end
            if (!tx_data_valid && host_q.size() > 0) begin
                tx_data       = host_q.pop_front();
                tx_data_valid = 1'b1;
            end
            prev_ready = tx_data_ready;
        end
    end

    // Pulse counters and the rx scoreboard, sampled away from the active edge.
    always @(negedge sys_clk) begin
        if (tx_underrun) ur_cnt++;
        if (frame_abort) ab_cnt++;
        if (rx_data_valid) begin
            rx_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL rx_unexpected: rx_data_valid pulsed with rx_data=0x%0h, required no pulse", rx_data);
            end else begin
                check_output("rx_data", rx_data, sb_q.pop_front());
            end
        end
    end

    // Behavioural master: clocks out count bits of word MSB first, captures miso.
    task automatic xfer(input logic cpol, input logic cpha, input int nbits,
                        input logic [31:0] word, input int count, output logic [31:0] captured);
        captured = 32'd0;
        for (int k = 0; k < count; k++) begin
            int b;
            b = nbits - 1 - k;
            if (!cpha) mosi = word[b];
            wait_clks(HALF);
            sclk = ~cpol;
            if (cpha) mosi = word[b];
            else      captured = {captured[30:0], miso};
            wait_clks(HALF);
            sclk = cpol;
            if (cpha) captured = {captured[30:0], miso};
        end
    endtask

    task automatic set_mode(input logic [15:0] ctl);
        sclk    = ctl[3];
        control = ctl;
        wait_clks(6);
    endtask

    task automatic load_tx(input logic [31:0] w);
        int n;
        n = 0;
        host_q.push_back(w);
        while (tx_data_ready && n < 50) begin
            wait_clks(1);
            n++;
        end
        check_output("tx_load", 32'(tx_data_ready), 32'd0);
    endtask

    // One complete single-frame exchange under its own cs_n assertion.
    task automatic apply_stimulus(input vec_t v, input string name);
        logic [31:0] cap;
        int          rx0;
        int          ab0;
        set_mode(v.ctl);
        load_tx(v.tx);
        sb_q.push_back(v.exp_rx);
        rx0  = rx_cnt;
        ab0  = ab_cnt;
        cs_n = 1'b0;
        wait_clks(HALF);
        check_output({name, "_ready"}, 32'(tx_data_ready), 32'd1);
        xfer(v.ctl[3], v.ctl[4], v.nbits, v.mosi, v.nbits, cap);
        wait_clks(HALF);
        check_output({name, "_oe"}, 32'(miso_oe), 32'd1);
        cs_n = 1'b1;
        wait_clks(HALF);
        check_output({name, "_miso"}, cap, v.exp_miso);
        check_output({name, "_rxcount"}, 32'(rx_cnt - rx0), 32'd1);
        check_output({name, "_abort"}, 32'(ab_cnt - ab0), 32'd0);
        check_output({name, "_sb"}, 32'(sb_q.size()), 32'd0);
        check_output({name, "_rxhold"}, rx_data, v.exp_rx);
        check_output({name, "_idle"}, {30'd0, miso_oe, miso}, 32'd0);
        last_rx = v.exp_rx;
    endtask

    initial begin
        vec_t        vecs[6];
        vec_t        v;
        logic [31:0] cap;
        logic [31:0] cap2;
        int          rx0;
        int          ab0;
        int          ur0;
        int          n;

        vecs[0] = '{mk_ctl(5'd7,  1'b0, 1'b0),  8, 32'h000000A5, 32'h0000003C, 32'h0000003C, 32'h000000A5};
        vecs[1] = '{mk_ctl(5'd15, 1'b0, 1'b1), 16, 32'h00008001, 32'h0000BEEF, 32'h0000BEEF, 32'h00008001};
        vecs[2] = '{mk_ctl(5'd15, 1'b1, 1'b0), 16, 32'h00008001, 32'h0000BEEF, 32'h0000BEEF, 32'h00008001};
        vecs[3] = '{mk_ctl(5'd15, 1'b1, 1'b1), 16, 32'h00008001, 32'h0000BEEF, 32'h0000BEEF, 32'h00008001};
        vecs[4] = '{mk_ctl(5'd31, 1'b0, 1'b0), 32, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'hDEADBEEF};
        vecs[5] = '{mk_ctl(5'd0,  1'b1, 1'b1),  8, 32'hFFFFFF3C, 32'h000000C3, 32'h000000C3, 32'h0000003C};

        sys_rst_n = 1'b0;
        cs_n      = 1'b1;
        sclk      = 1'b0;
        mosi      = 1'b0;
        control   = mk_ctl(5'd7, 1'b0, 1'b0);
        last_rx   = 32'd0;
        wait_clks(5);

        check_output("reset_miso", 32'(miso), 32'd0);
        check_output("reset_oe", 32'(miso_oe), 32'd0);
        check_output("reset_ready", 32'(tx_data_ready), 32'd1);
        check_output("reset_rx", rx_data, 32'd0);
        check_output("reset_pulses", {29'd0, rx_data_valid, tx_underrun, frame_abort}, 32'd0);
        sys_rst_n = 1'b1;
        wait_clks(5);

        // Single frames in every mode and at the length boundaries.
        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d", i);
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Three 32-bit frames in one burst with the host reloading on ready.
        $display("[TB] burst of three 32-bit frames");
        set_mode(mk_ctl(5'd31, 1'b0, 1'b0));
        load_tx(32'hCAFEF00D);
        host_q.push_back(32'h0F0F0F0F);
        host_q.push_back(32'h76543210);
        host_q.push_back(32'hFFFFFFFF);
        sb_q.push_back(32'h11111111);
        sb_q.push_back(32'h22222222);
        sb_q.push_back(32'h33333333);
        rx0 = rx_cnt; ur0 = ur_cnt; ab0 = ab_cnt;
        cs_n = 1'b0;
        wait_clks(HALF);
        xfer(1'b0, 1'b0, 32, 32'h11111111, 32, cap);
        check_output("burst_miso0", cap, 32'hCAFEF00D);
        xfer(1'b0, 1'b0, 32, 32'h22222222, 32, cap);
        check_output("burst_miso1", cap, 32'h0F0F0F0F);
        xfer(1'b0, 1'b0, 32, 32'h33333333, 32, cap);
        check_output("burst_miso2", cap, 32'h76543210);
        wait_clks(HALF);
        cs_n = 1'b1;
        wait_clks(HALF);
        check_output("burst_rxcount", 32'(rx_cnt - rx0), 32'd3);
        check_output("burst_underrun", 32'(ur_cnt - ur0), 32'd0);
        check_output("burst_abort", 32'(ab_cnt - ab0), 32'd0);
        check_output("burst_sb", 32'(sb_q.size()), 32'd0);
        check_output("burst_ready", 32'(tx_data_ready), 32'd1);

        // Second frame of a burst with nothing loaded sends zeros.
        $display("[TB] underrun on second frame");
        set_mode(mk_ctl(5'd7, 1'b0, 1'b1));
        load_tx(32'h00000096);
        sb_q.push_back(32'h0000005A);
        sb_q.push_back(32'h00000081);
        rx0 = rx_cnt; ur0 = ur_cnt;
        cs_n = 1'b0;
        wait_clks(HALF);
        xfer(1'b0, 1'b1, 8, 32'h5A, 8, cap);
        xfer(1'b0, 1'b1, 8, 32'h81, 8, cap2);
        wait_clks(HALF);
        cs_n = 1'b1;
        wait_clks(HALF);
        check_output("ur_miso0", cap, 32'h00000096);
        check_output("ur_miso1", cap2, 32'h00000000);
        check_output("ur_count", 32'(ur_cnt - ur0), 32'd1);
        check_output("ur_rxcount", 32'(rx_cnt - rx0), 32'd2);
        check_output("ur_sb", 32'(sb_q.size()), 32'd0);
        last_rx = 32'h00000081;

        // cs_n rises after five of eight bits.
        $display("[TB] abort after five bits");
        set_mode(mk_ctl(5'd7, 1'b0, 1'b0));
        load_tx(32'h000000F0);
        rx0 = rx_cnt; ab0 = ab_cnt;
        cs_n = 1'b0;
        wait_clks(HALF);
        xfer(1'b0, 1'b0, 8, 32'hAA, 5, cap);
        wait_clks(HALF);
        cs_n = 1'b1;
        wait_clks(HALF);
        check_output("abort_miso", cap, 32'h0000001E);
        check_output("abort_count", 32'(ab_cnt - ab0), 32'd1);
        check_output("abort_rxcount", 32'(rx_cnt - rx0), 32'd0);
        check_output("abort_rxhold", rx_data, last_rx);
        v = '{mk_ctl(5'd7, 1'b0, 1'b0), 8, 32'h0000003C, 32'h000000C5, 32'h000000C5, 32'h0000003C};
        apply_stimulus(v, "post_abort");

        // Reset in the middle of a frame, then a clean exchange.
        $display("[TB] reset mid-frame");
        load_tx(32'h00000077);
        rx0 = rx_cnt; ab0 = ab_cnt; ur0 = ur_cnt;
        cs_n = 1'b0;
        wait_clks(HALF);
        xfer(1'b0, 1'b0, 8, 32'h33, 3, cap);
        check_output("rst_partial", cap, 32'h00000003);
        sys_rst_n = 1'b0;
        wait_clks(2);
        check_output("rst_miso", 32'(miso), 32'd0);
        check_output("rst_oe", 32'(miso_oe), 32'd0);
        check_output("rst_ready", 32'(tx_data_ready), 32'd1);
        check_output("rst_rx", rx_data, 32'd0);
        check_output("rst_pulses", {29'd0, rx_data_valid, tx_underrun, frame_abort}, 32'd0);
        cs_n = 1'b1;
        wait_clks(4);
        sys_rst_n = 1'b1;
        wait_clks(4);
        check_output("rst_nopulse", 32'((rx_cnt - rx0) + (ab_cnt - ab0) + (ur_cnt - ur0)), 32'd0);
        v = '{mk_ctl(5'd7, 1'b0, 1'b0), 8, 32'h0000005A, 32'h0000005A, 32'h0000005A, 32'h0000005A};
        apply_stimulus(v, "post_reset");

        n = 0;
        while (host_q.size() > 0 && n < 20) begin
            wait_clks(1);
            n++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
